result_uart_tx: RTL and testbench



---
 rtl/uart_pkg.sv | 18 +
 rtl/result_uart_tx_if.sv | 12 +
 rtl/uart_byte_tx.sv | 55 +++++
 rtl/result_uart_tx.sv | 84 ++++++++
 tb/tb_result_uart_tx.sv | 190 +++++++++++++++++++
 5 files changed

// File: rtl/uart_pkg.sv
// uart_pkg: shared frame constants, report ASCII, state enum and hex helper for the result UART.
package uart_pkg;
  localparam int FRAME_BITS = 11;
  localparam int REPORT_LEN = 29;
  localparam int ERR_LEN = 5;
  localparam logic [7:0] ASCII_K = 8'h4B;
  localparam logic [7:0] ASCII_EQ = 8'h3D;
  localparam logic [7:0] ASCII_P = 8'h50;
  localparam logic [7:0] ASCII_E = 8'h45;
  localparam logic [7:0] ASCII_R = 8'h52;
  localparam logic [7:0] ASCII_SP = 8'h20;
  localparam logic [7:0] ASCII_CR = 8'h0D;
  localparam logic [7:0] ASCII_LF = 8'h0A;
  typedef enum logic [1:0] {IDLE, LOAD, SEND, FINISH} state_t;
  function automatic logic [7:0] hex_ascii(input logic [3:0] n);
    return (n < 4'd10) ? 8'h30 + {4'h0, n} : 8'h37 + {4'h0, n};
  endfunction
endpackage

// File: rtl/result_uart_tx_if.sv
// result_uart_tx_if: report request inputs and serial/status outputs of the result UART.
interface result_uart_tx_if;
  logic send;
  logic [23:0] key;
  logic [127:0] plaintext;
  logic error_in;
  logic tx_out;
  logic busy;
  logic tx_done;
  modport master(output send, key, plaintext, error_in, input tx_out, busy, tx_done);
  modport slave(input send, key, plaintext, error_in, output tx_out, busy, tx_done);
endinterface

// File: rtl/uart_byte_tx.sv
// uart_byte_tx: one 8O1 frame (start, 8 data LSB first, odd parity, stop) per start pulse.
module uart_byte_tx
  import uart_pkg::*;
#(
  parameter int BIT_PERIOD = 5208
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic [7:0] data,
  output logic       tx,
  output logic       done
);
  localparam int CW = (BIT_PERIOD > 1) ? $clog2(BIT_PERIOD) : 1;
  logic [CW-1:0] cnt;
  logic [3:0] bit_idx;
  logic [9:0] shift;
  logic active;
  always_ff @(posedge clk) begin
    if (rst) begin
      tx <= 1'b1;
      done <= 1'b0;
      cnt <= '0;
      bit_idx <= '0;
      shift <= '0;
      active <= 1'b0;
    end else begin
      done <= 1'b0;
      if (start && !active) begin
        active <= 1'b1;
        tx <= 1'b0;
        cnt <= '0;
        bit_idx <= '0;
        shift <= {1'b1, ~^data, data};
      end else if (active) begin
        if (cnt == CW'(BIT_PERIOD - 1)) begin
          cnt <= '0;
          // stop bit is already on the line when the last period expires
          if (bit_idx == 4'(FRAME_BITS - 1)) begin
            bit_idx <= '0;
            active <= 1'b0;
            done <= 1'b1;
            tx <= 1'b1;
          end else begin
            bit_idx <= bit_idx + 4'd1;
            tx <= shift[0];
            shift <= {1'b0, shift[9:1]};
          end
        end else begin
          cnt <= cnt + CW'(1);
        end
      end
    end
  end
endmodule

// File: rtl/result_uart_tx.sv
// result_uart_tx: snapshots codebreaker results on send and streams an ASCII report over UART.
module result_uart_tx
  import uart_pkg::*;
#(
  parameter int CLK_FREQUENCY = 100_000_000,
  parameter int BAUD_RATE = 19_200
) (
  input logic clk,
  input logic rst,
  result_uart_tx_if.slave bus
);
  localparam int BIT_PERIOD = CLK_FREQUENCY / BAUD_RATE;
  state_t state, state_n;
  logic [4:0] idx;
  logic [23:0] key_s;
  logic [127:0] pt_s;
  logic err_s;
  logic last;
  logic byte_done;
  logic start;
  logic [4:0] ni;
  logic [4:0] pi;
  logic [3:0] nib;
  logic [7:0] pt_byte;
  logic [7:0] err_byte;
  logic [7:0] rpt_byte;
  logic [7:0] cur_byte;
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      idx <= '0;
      key_s <= '0;
      pt_s <= '0;
      err_s <= 1'b0;
    end else begin
      state <= state_n;
      if (state == IDLE && bus.send) begin
        key_s <= bus.key;
        pt_s <= bus.plaintext;
        err_s <= bus.error_in;
        idx <= '0;
      end
      if (state == SEND && byte_done && !last) idx <= idx + 5'd1;
    end
  end
  always_comb begin
    state_n = state;
    state_n = state == IDLE ? (bus.send ? LOAD : IDLE)
            : state == LOAD ? SEND
            : state == SEND ? (byte_done ? (last ? FINISH : LOAD) : SEND)
            : IDLE;
  end
  assign last = idx == (err_s ? 5'(ERR_LEN - 1) : 5'(REPORT_LEN - 1));
  assign start = state == LOAD;
  assign bus.busy = state == LOAD || state == SEND;
  assign bus.tx_done = state == FINISH;
  // key nibble for hex positions 2..7, plaintext byte for positions 11..26
  assign ni = 5'd7 - idx;
  assign pi = 5'd26 - idx;
  assign nib = 4'(key_s >> {ni, 2'b00});
  assign pt_byte = 8'(pt_s >> {pi, 3'b000});
  assign err_byte = idx == 5'd0 ? ASCII_E
                  : idx < 5'd3 ? ASCII_R
                  : idx == 5'd3 ? ASCII_CR
                  : ASCII_LF;
  assign rpt_byte = idx == 5'd0 ? ASCII_K
                  : idx == 5'd1 ? ASCII_EQ
                  : idx < 5'd8 ? hex_ascii(nib)
                  : idx == 5'd8 ? ASCII_SP
                  : idx == 5'd9 ? ASCII_P
                  : idx == 5'd10 ? ASCII_EQ
                  : idx < 5'd27 ? pt_byte
                  : idx == 5'd27 ? ASCII_CR
                  : ASCII_LF;
  assign cur_byte = err_s ? err_byte : rpt_byte;
  uart_byte_tx #(.BIT_PERIOD(BIT_PERIOD)) u_byte_tx (
    .clk(clk),
    .rst(rst),
    .start(start),
    .data(cur_byte),
    .tx(bus.tx_out),
    .done(byte_done)
  );
endmodule

// File: tb/tb_result_uart_tx.sv
// tb_result_uart_tx: decodes the serial line and checks reports against hand-written expected streams.
module tb_result_uart_tx;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int tests = 0;
  int fails = 0;
  result_uart_tx_if bus();
  result_uart_tx #(.CLK_FREQUENCY(1_000_000), .BAUD_RATE(100_000)) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );
  always #5 clk = ~clk;
  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation did not finish, got timeout required completion");
    $fatal(1);
  end

  typedef struct {
    logic [23:0] key;
    logic err;
    logic [47:0] hex;
    logic [127:0] pt;
  } vec_t;
  vec_t vecs[6];

  logic [7:0] rx_q[$];
  logic samp[110];
  int mon_n = 0;
  int idle_run = 0;
  int done_cnt = 0;
  int frame_bad = 0;
  int gap_bad = 0;
  int busy_bad = 0;
  bit have_prev = 0;
  logic [7:0] b;
  bit hold_ok;

  // line monitor: 110 samples per frame, one per clock, starting at the start bit
  always @(negedge clk) begin
    if (rst) begin
      mon_n = 0;
      have_prev = 0;
    end else begin
      if (bus.tx_done) begin
        done_cnt++;
        have_prev = 0;
      end
      if (mon_n == 0) begin
        if (!bus.tx_out) begin
          if (have_prev && idle_run > 2) gap_bad++;
          samp[0] = 1'b0;
          mon_n = 1;
        end else begin
          idle_run++;
        end
      end else begin
        samp[mon_n] = bus.tx_out;
        mon_n++;
        if (mon_n == 110) begin
          hold_ok = 1;
          for (int k = 0; k < 11; k++)
            for (int j = 0; j < 10; j++)
              if (samp[10*k+j] != samp[10*k]) hold_ok = 0;
          for (int k = 0; k < 8; k++) b[k] = samp[10*(k+1)+5];
          if (!hold_ok || samp[5] != 1'b0 || samp[105] != 1'b1 || (^b ^ samp[95]) != 1'b1) frame_bad++;
          rx_q.push_back(b);
          mon_n = 0;
          idle_run = 0;
          have_prev = 1;
        end
      end
      if (mon_n != 0 && !bus.busy) busy_bad++;
    end
  end

  task automatic check(input string name, input logic [231:0] got, input logic [231:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got %0h required %0h", name, got, exp);
    end
  endtask

  function automatic logic [231:0] exp_stream(input logic err, input logic [47:0] hex, input logic [127:0] pt);
    return err ? 232'({"ERR", 8'h0D, 8'h0A}) : {"K=", hex, " P=", pt, 8'h0D, 8'h0A};
  endfunction

  task automatic start_report(input logic [23:0] k, input logic [127:0] p, input logic e);
    @(posedge clk); #1;
    rx_q.delete();
    done_cnt = 0;
    frame_bad = 0;
    gap_bad = 0;
    busy_bad = 0;
    bus.key = k;
    bus.plaintext = p;
    bus.error_in = e;
    bus.send = 1'b1;
    @(posedge clk); #1;
    bus.send = 1'b0;
  endtask

  task automatic finish_report(input string name, input int len, input logic [231:0] exp);
    logic [231:0] got;
    int n;
    got = '0;
    n = 0;
    while (done_cnt == 0 && n < 4000) begin
      @(posedge clk);
      n++;
    end
    check({name, "_done_seen"}, 232'(done_cnt > 0), 232'(1));
    repeat (30) @(posedge clk);
    for (int i = 0; i < rx_q.size() && i < len; i++) got[8*(len-1-i) +: 8] = rx_q[i];
    check({name, "_len"}, 232'(rx_q.size()), 232'(len));
    check({name, "_stream"}, got, exp);
    check({name, "_done_once"}, 232'(done_cnt), 232'(1));
    check({name, "_frames"}, 232'(frame_bad), 232'(0));
    check({name, "_gap"}, 232'(gap_bad), 232'(0));
    check({name, "_busy"}, 232'(busy_bad), 232'(0));
  endtask

  task automatic wait_bytes(input int cnt);
    for (int i = 0; i < 5000 && rx_q.size() < cnt; i++) @(posedge clk);
  endtask

  initial begin
    vecs[0] = '{24'h0A1B2C, 1'b0, "0A1B2C", "Hello, World!!!!"};
    vecs[1] = '{24'hF9A000, 1'b0, "F9A000", "Hello, World!!!!"};
    vecs[2] = '{24'h000000, 1'b0, "000000", "0123456789abcdef"};
    vecs[3] = '{24'hFFFFFF, 1'b0, "FFFFFF", "ABCDEFGHIJKLMNOP"};
    vecs[4] = '{24'h9ABCDE, 1'b1, "000000", "Hello, World!!!!"};
    vecs[5] = '{24'h123456, 1'b0, "123456", "zyxwvutsrqponmlk"};
    bus.send = 1'b0;
    bus.key = '0;
    bus.plaintext = '0;
    bus.error_in = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("reset_tx_out", 232'(bus.tx_out), 232'(1));
    check("reset_busy", 232'(bus.busy), 232'(0));
    check("reset_tx_done", 232'(bus.tx_done), 232'(0));
    @(posedge clk); #1;
    rst = 1'b0;
    repeat (3) @(posedge clk);

    start_report(vecs[0].key, vecs[0].pt, 1'b0);
    check("latency_line_idle", 232'(bus.tx_out), 232'(1));
    check("latency_busy", 232'(bus.busy), 232'(1));
    @(posedge clk); #1;
    check("latency_start_bit", 232'(bus.tx_out), 232'(0));
    finish_report("first", 29, exp_stream(1'b0, vecs[0].hex, vecs[0].pt));

    for (int v = 0; v < 6; v++) begin
      start_report(vecs[v].key, vecs[v].pt, vecs[v].err);
      finish_report($sformatf("vec%0d", v), vecs[v].err ? 5 : 29,
                    exp_stream(vecs[v].err, vecs[v].hex, vecs[v].pt));
    end

    start_report(vecs[0].key, vecs[0].pt, 1'b0);
    wait_bytes(3);
    @(posedge clk); #1;
    bus.key = 24'hFFFFFF;
    bus.send = 1'b1;
    @(posedge clk); #1;
    bus.send = 1'b0;
    finish_report("resend", 29, exp_stream(1'b0, vecs[0].hex, vecs[0].pt));
    repeat (400) @(posedge clk);
    check("resend_no_second", 232'(rx_q.size()), 232'(29));

    start_report(vecs[1].key, vecs[1].pt, 1'b0);
    wait_bytes(5);
    repeat (50) @(posedge clk);
    #1;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    check("abort_tx_out", 232'(bus.tx_out), 232'(1));
    check("abort_busy", 232'(bus.busy), 232'(0));
    repeat (400) @(posedge clk);
    check("abort_no_done", 232'(done_cnt), 232'(0));
    start_report(vecs[1].key, vecs[1].pt, 1'b0);
    finish_report("after_abort", 29, exp_stream(1'b0, vecs[1].hex, vecs[1].pt));

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
